// File: rtl/ram_dma_engine_pkg.sv
// Shared definitions for the RAM DMA engine: FSM state encoding.
package ram_dma_engine_pkg;

    // Encoding is fixed: IDLE=0, RD=1, WR=2, FIN=3.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StFin  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/ram_dma_csum.sv
// Wrapping word accumulator with synchronous clear and enable.
module ram_dma_csum #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    // Clear wins over enable; both never coincide in the engine.
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + data_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ram_dma_engine.sv
// RAM-to-RAM copy engine driving a single-port synchronous RAM.
// Each word costs one read cycle and one write cycle; abort is honoured in either.
// Optional feature: define RAM_DMA_CHECKSUM_EN to add a csum_o output that sums
// every word written during the transfer.
module ram_dma_engine
    import ram_dma_engine_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic [ADDR_WIDTH:0]   words_done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef RAM_DMA_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] csum_o
`endif
);

    localparam logic [ADDR_WIDTH:0] IdxOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    dma_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic                  aborted_q, aborted_d;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic                  start_acc;

    assign idx_inc   = idx_q + IdxOne;
    assign start_acc = (state_q == StIdle) && start_i;

    // Next-state logic: latch the request on start, step the index on each write.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        idx_d     = idx_q;
        aborted_d = aborted_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    src_d     = src_addr_i;
                    dst_d     = dst_addr_i;
                    len_d     = length_i;
                    idx_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = (length_i == '0) ? StFin : StRd;
                end
            end
            StRd: begin
                // Abort here drops the pending word without writing it.
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = StFin;
                end else begin
                    state_d = StWr;
                end
            end
            StWr: begin
                // This cycle's write always completes, abort or not.
                idx_d = idx_inc;
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = StFin;
                end else if (idx_inc == len_q) begin
                    state_d = StFin;
                end else begin
                    state_d = StRd;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            aborted_q <= aborted_d;
        end
    end

    // RAM port decode; the address adders wrap naturally at ADDR_WIDTH bits.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            StRd: begin
                mem_addr_o = src_q + idx_q[ADDR_WIDTH-1:0];
            end
            StWr: begin
                mem_addr_o  = dst_q + idx_q[ADDR_WIDTH-1:0];
                mem_we_o    = 1'b1;
                mem_wdata_o = mem_rdata_i;
            end
            default: ;
        endcase
    end

    assign busy_o       = (state_q == StRd) || (state_q == StWr);
    assign done_o       = (state_q == StFin);
    assign aborted_o    = aborted_q;
    assign words_done_o = idx_q;

`ifdef RAM_DMA_CHECKSUM_EN
    ram_dma_csum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start_acc),
        .en_i  (state_q == StWr),
        .data_i(mem_rdata_i),
        .sum_o (csum_o)
    );
`else
    // No accumulator in this build; start_acc only feeds the checksum clear.
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine with a behavioural single-port RAM.
// Latency is counted with the start cycle as cycle 1.
module tb_ram_dma_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [8:0]  length;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [8:0]  words_done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
`ifdef RAM_DMA_CHECKSUM_EN
    logic [31:0] csum;
`endif

    // Bench-side preload port, muxed into the RAM while the engine is idle.
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [31:0] tb_wdata;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] mem [256];

    int n_tests;
    int n_fail;
    int wr_cnt;
    int done_cnt;

    logic [31:0] a_data [4];

    ram_dma_engine #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .src_addr_i  (src_addr),
        .dst_addr_i  (dst_addr),
        .length_i    (length),
        .busy_o      (busy),
        .done_o      (done),
        .aborted_o   (aborted),
        .words_done_o(words_done),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata)
`ifdef RAM_DMA_CHECKSUM_EN
        ,
        .csum_o      (csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_we    = mem_we | tb_we;
    assign ram_addr  = tb_we ? tb_addr : mem_addr;
    assign ram_wdata = tb_we ? tb_wdata : mem_wdata;

    // Write-first single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        mem_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end

    // Event counters; tests compare deltas.
    always @(posedge clk) begin
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_addr  = addr;
        tb_wdata = data;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Runs one transfer; abort_rd/abort_wr pick the Nth RD/WR cycle to abort in
    // (0 = never), restart_at pulses a competing start in that cycle (0 = never).
    task automatic run_xfer(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                            input int abort_rd, input int abort_wr, input int restart_at,
                            output int cyc, output bit seen_done);
        int rd_seen;
        int wr_seen;
        rd_seen = 0;
        wr_seen = 0;
        @(negedge clk);
        start     = 1'b1;
        src_addr  = src;
        dst_addr  = dst;
        length    = len;
        abort     = 1'b0;
        cyc       = 1;
        seen_done = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy && !mem_we) begin
                rd_seen++;
                if (rd_seen == abort_rd) abort = 1'b1;
            end
            if (busy && mem_we) begin
                wr_seen++;
                if (wr_seen == abort_wr) abort = 1'b1;
            end
            if (cyc == restart_at) begin
                start    = 1'b1;
                src_addr = 8'h20;
                dst_addr = 8'hC0;
                length   = 9'd2;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int          cyc;
        bit          seen;
        int          wr0;
        int          dn0;
        logic [31:0] sum;

        n_tests  = 0;
        n_fail   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        a_data[0] = 32'hCAFE_0000;
        a_data[1] = 32'h1234_5678;
        a_data[2] = 32'hFFFF_FFFF;
        a_data[3] = 32'h0000_0010;

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_aborted", 32'(aborted), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_words", 32'(words_done), 32'd0);
        rst_n = 1'b1;

        // 1: straight copy of four words.
        for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), a_data[i]);
        wr0 = wr_cnt;
        run_xfer(8'h10, 8'h80, 9'd4, 0, 0, 0, cyc, seen);
        check_eq("t1_done", 32'(seen), 32'd1);
        check_eq("t1_latency", 32'(cyc), 32'd10);
        check_eq("t1_words", 32'(words_done), 32'd4);
        check_eq("t1_aborted", 32'(aborted), 32'd0);
`ifdef RAM_DMA_CHECKSUM_EN
        sum = 32'd0;
        for (int i = 0; i < 4; i++) sum = sum + a_data[i];
        check_eq("t1_csum", csum, sum);
`else
        sum = 32'd0;
`endif
        @(negedge clk);
        check_eq("t1_writes", 32'(wr_cnt - wr0), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("t1_mem", mem[8'h80 + i], a_data[i]);

        // 2: zero-length transfer.
        wr0 = wr_cnt;
        run_xfer(8'h10, 8'h50, 9'd0, 0, 0, 0, cyc, seen);
        check_eq("t2_done", 32'(seen), 32'd1);
        check_eq("t2_latency", 32'(cyc), 32'd2);
        check_eq("t2_words", 32'(words_done), 32'd0);
        @(negedge clk);
        check_eq("t2_writes", 32'(wr_cnt - wr0), 32'd0);

        // 3: wrapping, overlapping forward copy.
        poke(8'hFE, 32'd1);
        poke(8'hFF, 32'd2);
        poke(8'h00, 32'd3);
        poke(8'h01, 32'd9);
        run_xfer(8'hFE, 8'hFF, 9'd3, 0, 0, 0, cyc, seen);
        check_eq("t3_done", 32'(seen), 32'd1);
        @(negedge clk);
        check_eq("t3_mem_ff", mem[8'hFF], 32'd1);
        check_eq("t3_mem_00", mem[8'h00], 32'd1);
        check_eq("t3_mem_01", mem[8'h01], 32'd1);

        // 4a: abort in the third read.
        for (int i = 0; i < 8; i++) poke(8'(8'h20 + i), 32'h5000_0000 + 32'(i));
        for (int i = 0; i < 8; i++) poke(8'(8'h40 + i), 32'hDEAD_0000 + 32'(i));
        wr0 = wr_cnt;
        run_xfer(8'h20, 8'h40, 9'd8, 3, 0, 0, cyc, seen);
        check_eq("t4a_done", 32'(seen), 32'd1);
        check_eq("t4a_latency", 32'(cyc), 32'd7);
        check_eq("t4a_aborted", 32'(aborted), 32'd1);
        check_eq("t4a_words", 32'(words_done), 32'd2);
        @(negedge clk);
        check_eq("t4a_writes", 32'(wr_cnt - wr0), 32'd2);
        check_eq("t4a_mem1", mem[8'h41], 32'h5000_0001);
        check_eq("t4a_mem2", mem[8'h42], 32'hDEAD_0002);
        check_eq("t4a_aborted_hold", 32'(aborted), 32'd1);

        // 4b: abort in the third write.
        wr0 = wr_cnt;
        run_xfer(8'h20, 8'h60, 9'd8, 0, 3, 0, cyc, seen);
        check_eq("t4b_done", 32'(seen), 32'd1);
        check_eq("t4b_latency", 32'(cyc), 32'd8);
        check_eq("t4b_aborted", 32'(aborted), 32'd1);
        check_eq("t4b_words", 32'(words_done), 32'd3);
        @(negedge clk);
        check_eq("t4b_writes", 32'(wr_cnt - wr0), 32'd3);
        check_eq("t4b_mem2", mem[8'h62], 32'h5000_0002);

        // 5: competing start while busy is dropped.
        poke(8'hC0, 32'hBEEF_0000);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        run_xfer(8'h10, 8'h90, 9'd4, 0, 0, 3, cyc, seen);
        check_eq("t5_done", 32'(seen), 32'd1);
        check_eq("t5_latency", 32'(cyc), 32'd10);
        check_eq("t5_aborted", 32'(aborted), 32'd0);
        repeat (8) @(negedge clk);
        check_eq("t5_writes", 32'(wr_cnt - wr0), 32'd4);
        check_eq("t5_done_cnt", 32'(done_cnt - dn0), 32'd1);
        check_eq("t5_mem3", mem[8'h93], a_data[3]);
        check_eq("t5_untouched", mem[8'hC0], 32'hBEEF_0000);

        // 6: asynchronous reset after two words.
        for (int i = 0; i < 4; i++) poke(8'(8'hA0 + i), 32'h7700_0000);
        dn0 = done_cnt;
        @(negedge clk);
        start    = 1'b1;
        src_addr = 8'h10;
        dst_addr = 8'hA0;
        length   = 9'd4;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (words_done == 9'd2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t6_reached", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_we", 32'(mem_we), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t6_no_done", 32'(done_cnt - dn0), 32'd0);
        check_eq("t6_mem1", mem[8'hA1], a_data[1]);
        check_eq("t6_mem2", mem[8'hA2], 32'h7700_0000);
        run_xfer(8'h10, 8'hB0, 9'd4, 0, 0, 0, cyc, seen);
        check_eq("t6_fresh_done", 32'(seen), 32'd1);
        check_eq("t6_fresh_latency", 32'(cyc), 32'd10);
        @(negedge clk);
        check_eq("t6_fresh_mem0", mem[8'hB0], a_data[0]);
        check_eq("t6_fresh_mem3", mem[8'hB3], a_data[3]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
